// File: rtl/vx_table_sched.sv
// Round-robin scheduler sharing one associative lookup table among NUM_REQS requesters.
// One command is in flight at a time; each requester gets a one-hot tagged response.
module vx_table_sched #(
    parameter int NUM_REQS = 4,
    parameter int ADDRW    = 4,
    parameter int DATAW    = 4,
    parameter int TIMEOUT  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQS-1:0]   req_valid,
    input  logic [NUM_REQS*3-1:0] req_action,
    input  logic [NUM_REQS*ADDRW-1:0] req_addr,
    input  logic [NUM_REQS*DATAW-1:0] req_data,
    output logic [NUM_REQS-1:0]   req_ready,
    output logic [NUM_REQS-1:0]   rsp_valid,
    output logic                  rsp_hit,
    output logic [DATAW-1:0]      rsp_data,
    output logic                  rsp_err,
    output logic                  tbl_valid,
    output logic [2:0]            tbl_action,
    output logic [ADDRW-1:0]      tbl_addr,
    output logic [DATAW-1:0]      tbl_data,
    input  logic                  tbl_done,
    input  logic                  tbl_hit,
    input  logic [DATAW-1:0]      tbl_rdata,
    input  logic                  tbl_full,
    output logic                  busy
);
    localparam int PW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t           state;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    grant;
    logic [CW-1:0]    cnt;
    logic [PW-1:0]    win;
    logic             win_found;
    logic [2:0]       win_action;
    logic [ADDRW-1:0] win_addr;
    logic [DATAW-1:0] win_data;
    logic             reject;

    // Search order starts at ptr and wraps, so the last served requester goes last.
    always_comb begin
        int idx;
        idx       = 0;
        win       = '0;
        win_found = 1'b0;
        for (int k = 0; k < NUM_REQS; k++) begin
            idx = (int'(ptr) + k) % NUM_REQS;
            if (!win_found && req_valid[idx]) begin
                win_found = 1'b1;
                win       = PW'(idx);
            end
        end
    end

    always_comb begin
        win_action = req_action[3*int'(win) +: 3];
        win_addr   = req_addr[ADDRW*int'(win) +: ADDRW];
        win_data   = req_data[DATAW*int'(win) +: DATAW];
        reject     = (win_action > 3'd4) || ((win_action == 3'd1) && tbl_full);
    end

    assign req_ready = (state == IDLE && reset && win_found) ? (NUM_REQS'(1) << win) : '0;
    assign tbl_valid = (state == BUSY);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            ptr        <= '0;
            grant      <= '0;
            cnt        <= '0;
            tbl_action <= '0;
            tbl_addr   <= '0;
            tbl_data   <= '0;
            rsp_valid  <= '0;
            rsp_hit    <= 1'b0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
        end else begin
            // Response fields are single-cycle strobes; they fall back to zero by default.
            rsp_valid <= '0;
            rsp_hit   <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        grant      <= win;
                        tbl_action <= win_action;
                        tbl_addr   <= win_addr;
                        tbl_data   <= win_data;
                        cnt        <= '0;
                        if (reject) begin
                            state     <= RESP;
                            rsp_valid <= NUM_REQS'(1) << win;
                            rsp_err   <= 1'b1;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt + 1'b1;
                    if (tbl_done) begin
                        state     <= RESP;
                        rsp_valid <= NUM_REQS'(1) << grant;
                        rsp_hit   <= (tbl_action == 3'd0) && tbl_hit;
                        rsp_data  <= (tbl_action == 3'd4) ? tbl_rdata : '0;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        state     <= RESP;
                        rsp_valid <= NUM_REQS'(1) << grant;
                        rsp_err   <= 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    ptr   <= (grant == PW'(NUM_REQS - 1)) ? '0 : grant + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vx_table_sched.sv
// Bench for vx_table_sched: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_vx_table_sched;
    localparam int N  = 4;
    localparam int AW = 4;
    localparam int DW = 4;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*3-1:0]  req_action = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic            rsp_hit;
    logic [DW-1:0]   rsp_data;
    logic            rsp_err;
    logic            tbl_valid;
    logic [2:0]      tbl_action;
    logic [AW-1:0]   tbl_addr;
    logic [DW-1:0]   tbl_data;
    logic            tbl_done = 1'b0;
    logic            tbl_hit = 1'b0;
    logic [DW-1:0]   tbl_rdata = '0;
    logic            tbl_full = 1'b0;
    logic            busy;

    always #5 clk = ~clk;

    vx_table_sched #(.NUM_REQS(N), .ADDRW(AW), .DATAW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_action(req_action), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .tbl_valid(tbl_valid), .tbl_action(tbl_action), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .tbl_done(tbl_done), .tbl_hit(tbl_hit), .tbl_rdata(tbl_rdata), .tbl_full(tbl_full),
        .busy(busy)
    );

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    bit chk_en = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        else n_pass++;
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    // Reference model: one operation at a time, phase 0 waiting, 1 at table, 2 answering.
    int            m_phase = 0;
    int            m_ptr = 0;
    int            m_g = 0;
    int            m_n = 0;
    logic [2:0]    m_act = '0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;
    logic          m_hit = 1'b0;
    logic          m_err = 1'b0;
    logic [DW-1:0] m_rdata = '0;
    logic [N-1:0]  m_acc = '0;

    always @(posedge clk) begin
        int w;
        m_acc = '0;
        if (!reset) begin
            m_phase = 0; m_ptr = 0; m_act = '0; m_addr = '0; m_data = '0;
        end else if (m_phase == 0) begin
            w = rr_pick(req_valid, m_ptr);
            if (w >= 0) begin
                m_g = w; m_acc[w] = 1'b1;
                m_act = req_action[w*3 +: 3]; m_addr = req_addr[w*AW +: AW]; m_data = req_data[w*DW +: DW];
                m_hit = 1'b0; m_rdata = '0;
                if (m_act > 3'd4 || (m_act == 3'd1 && tbl_full)) begin
                    m_phase = 2; m_err = 1'b1;
                end else begin
                    m_phase = 1; m_n = 0;
                end
            end
        end else if (m_phase == 1) begin
            m_n++;
            if (tbl_done) begin
                m_phase = 2; m_err = 1'b0;
                m_hit = (m_act == 3'd0) ? tbl_hit : 1'b0;
                m_rdata = (m_act == 3'd4) ? tbl_rdata : '0;
            end else if (m_n == TO) begin
                m_phase = 2; m_err = 1'b1; m_hit = 1'b0; m_rdata = '0;
            end
        end else begin
            m_ptr = (m_g + 1) % N;
            m_phase = 0;
        end
    end

    // Observation logs used by the directed scenarios.
    int acc_q[$];
    int rsp_g_q[$];
    int rsp_cyc_q[$];
    int rsp_err_q[$];
    int rsp_hit_q[$];
    int rsp_data_q[$];
    int tv_total = 0;

    always @(negedge clk) begin
        int w;
        logic [N-1:0] exp_ready;
        #3;
        if (chk_en) begin
            w = rr_pick(req_valid, m_ptr);
            exp_ready = (m_phase == 0 && reset && w >= 0) ? (N'(1) << w) : '0;
            chk("req_ready", 32'(req_ready), 32'(exp_ready));
            chk("tbl_valid", 32'(tbl_valid), 32'(m_phase == 1));
            chk("busy", 32'(busy), 32'(m_phase != 0));
            chk("tbl_cmd", 32'({tbl_action, tbl_addr, tbl_data}), 32'({m_act, m_addr, m_data}));
            chk("rsp_valid", 32'(rsp_valid), (m_phase == 2) ? (32'd1 << m_g) : 32'd0);
            chk("rsp_fields", 32'({rsp_hit, rsp_err, rsp_data}),
                (m_phase == 2) ? 32'({m_hit, m_err, m_rdata}) : 32'd0);
        end
        if (reset && |(req_valid & req_ready)) acc_q.push_back(cyc);
        if (rsp_valid != '0) begin
            w = -1;
            for (int i = 0; i < N; i++) if (rsp_valid == (N'(1) << i)) w = i;
            rsp_g_q.push_back(w);
            rsp_cyc_q.push_back(cyc);
            rsp_err_q.push_back(int'(rsp_err));
            rsp_hit_q.push_back(int'(rsp_hit));
            rsp_data_q.push_back(int'(rsp_data));
        end
        if (tbl_valid) tv_total++;
    end

    // Stimulus state, applied to the DUT pins once per cycle at the falling edge.
    logic [N-1:0]  pend = '0;
    logic [N-1:0]  keep = '0;
    logic [2:0]    act_v[N];
    logic [AW-1:0] addr_v[N];
    logic [DW-1:0] data_v[N];
    logic          rst_v = 1'b0;
    logic          full_v = 1'b0;
    logic          hit_v = 1'b0;
    logic [DW-1:0] rdata_v = '0;
    bit            rand_mode = 0;
    int            done_after = 0;
    int            vcnt = 0;
    int            cur_da = 0;

    task automatic step();
        @(negedge clk);
        for (int i = 0; i < N; i++) if (m_acc[i] && !keep[i]) pend[i] = 1'b0;
        if (rand_mode) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i]) begin
                    if ($urandom_range(0, 9) < 3) begin
                        pend[i] = 1'b1;
                        act_v[i] = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
                        addr_v[i] = AW'($urandom);
                        data_v[i] = DW'($urandom);
                    end
                end else if ($urandom_range(0, 99) < 3) begin
                    pend[i] = 1'b0;
                end
            end
            full_v = ($urandom_range(0, 4) == 0);
            hit_v = 1'($urandom);
            rdata_v = DW'($urandom);
            rst_v = ($urandom_range(0, 399) != 0);
        end
        // Table responder: asserts done on the cur_da-th command cycle (0 = never).
        if (tbl_valid) begin
            if (vcnt == 0) cur_da = rand_mode ? int'($urandom_range(1, 18)) : done_after;
            vcnt++;
            tbl_done = (cur_da != 0 && vcnt == cur_da);
        end else begin
            vcnt = 0;
            tbl_done = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            req_valid[i] = pend[i];
            req_action[i*3 +: 3] = act_v[i];
            req_addr[i*AW +: AW] = addr_v[i];
            req_data[i*DW +: DW] = data_v[i];
        end
        tbl_full = full_v;
        tbl_hit = hit_v;
        tbl_rdata = rdata_v;
        reset = rst_v;
    endtask

    int base_a, base_r, base_tv;

    task automatic mark();
        base_a = acc_q.size();
        base_r = rsp_g_q.size();
        base_tv = tv_total;
    endtask

    task automatic issue(input int r, input logic [2:0] a, input logic [AW-1:0] ad, input logic [DW-1:0] d);
        pend[r] = 1'b1; act_v[r] = a; addr_v[r] = ad; data_v[r] = d;
    endtask

    // Checks the single response of a one-request scenario against literal values.
    task automatic check_one(input string tag, input int g, input int lat, input int tv,
                             input int err, input int hit, input int data);
        chk({tag, "_count"}, 32'(rsp_g_q.size() - base_r), 32'd1);
        chk({tag, "_grant"}, 32'(rsp_g_q[base_r]), 32'(g));
        chk({tag, "_latency"}, 32'(rsp_cyc_q[base_r] - acc_q[base_a]), 32'(lat));
        chk({tag, "_tbl_cycles"}, 32'(tv_total - base_tv), 32'(tv));
        chk({tag, "_err"}, 32'(rsp_err_q[base_r]), 32'(err));
        chk({tag, "_hit"}, 32'(rsp_hit_q[base_r]), 32'(hit));
        chk({tag, "_data"}, 32'(rsp_data_q[base_r]), 32'(data));
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin act_v[i] = '0; addr_v[i] = '0; data_v[i] = '0; end
        rst_v = 1'b0;
        repeat (3) step();
        chk_en = 1;
        #3;
        chk("reset_tbl_valid", 32'(tbl_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_tbl_cmd", 32'({tbl_action, tbl_addr, tbl_data}), 32'd0);
        rst_v = 1'b1;
        repeat (2) step();

        // Single add; hit/rdata from the table must be masked for an add.
        mark(); done_after = 2; hit_v = 1'b1; rdata_v = 4'hF;
        issue(0, 3'd1, 4'd3, 4'd5);
        repeat (10) step();
        check_one("single_add", 0, 3, 2, 0, 0, 0);

        // Round robin from a fresh reset.
        rst_v = 1'b0; step(); rst_v = 1'b1; step();
        mark(); done_after = 1; hit_v = 1'b0;
        for (int i = 0; i < N; i++) issue(i, 3'd0, AW'(i), '0);
        keep = '1;
        repeat (16) step();
        keep = '0; pend = '0;
        repeat (20) step();
        chk("rr_count", 32'(rsp_g_q.size() - base_r >= 5), 32'd1);
        for (int k = 0; k < 5; k++) begin
            chk("rr_order", 32'(rsp_g_q[base_r + k]), 32'(k % N));
            if (k > 0) chk("rr_interval", 32'(rsp_cyc_q[base_r + k] - rsp_cyc_q[base_r + k - 1]), 32'd3);
        end

        // Get then is_present on requester 2.
        mark(); done_after = 1; rdata_v = 4'hA; hit_v = 1'b1;
        issue(2, 3'd4, 4'd7, 4'd0);
        repeat (8) step();
        check_one("get", 2, 2, 1, 0, 0, 10);
        mark(); issue(2, 3'd0, 4'd7, 4'd0);
        repeat (8) step();
        check_one("present", 2, 2, 1, 0, 1, 0);

        // Rejections: illegal action, then add while full.
        mark(); issue(1, 3'd5, 4'd1, 4'd1);
        repeat (6) step();
        check_one("reject_act", 1, 1, 0, 1, 0, 0);
        mark(); full_v = 1'b1; issue(1, 3'd1, 4'd2, 4'd2);
        repeat (6) step();
        full_v = 1'b0;
        check_one("reject_full", 1, 1, 0, 1, 0, 0);

        // Timeout, then done arriving on the final allowed cycle.
        mark(); done_after = 0; issue(3, 3'd2, 4'd9, 4'd3);
        repeat (25) step();
        check_one("timeout", 3, TO + 1, TO, 1, 0, 0);
        mark(); done_after = TO; issue(3, 3'd2, 4'd9, 4'd4);
        repeat (25) step();
        check_one("done_last", 3, TO + 1, TO, 0, 0, 0);

        // Serve requester 1 so the round-robin pointer moves off zero, then abort a request.
        done_after = 1; hit_v = 1'b0;
        issue(1, 3'd0, 4'd1, 4'd0);
        repeat (8) step();
        mark(); done_after = 0;
        issue(2, 3'd3, 4'd5, 4'd0);
        step(); step();
        rst_v = 1'b0; step();
        rst_v = 1'b1; step();
        #3;
        chk("abort_tbl_valid", 32'(tbl_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        repeat (25) step();
        chk("abort_no_rsp", 32'(rsp_g_q.size() - base_r), 32'd0);
        mark(); done_after = 1;
        issue(1, 3'd0, 4'd2, 4'd0);
        issue(3, 3'd0, 4'd3, 4'd0);
        repeat (12) step();
        chk("after_abort_count", 32'(rsp_g_q.size() - base_r), 32'd2);
        chk("after_abort_first", 32'(rsp_g_q[base_r]), 32'd1);
        chk("after_abort_second", 32'(rsp_g_q[base_r + 1]), 32'd3);
        chk("after_abort_err", 32'(rsp_err_q[base_r]), 32'd0);

        // Randomized traffic against the model.
        rand_mode = 1;
        repeat (3000) step();
        rand_mode = 0; pend = '0; rst_v = 1'b1; full_v = 1'b0;
        repeat (25) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
